// File: rtl/cby_blwl_config_ctrl.sv
// Memory-bank configuration sequencer for BL/WL programmed connection blocks.
// Assembles one BL frame per WL row from a stream of DIN_W-bit words, then
// drives the frame on bl while pulsing the row's word line.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; din ignored, nothing driven
// S_LOAD  | accepting words into the shadow frame for row_idx
// S_SETUP | one cycle of bit-line settle before the word-line pulse
// S_PULSE | wl[row_idx] high for WL_PULSE cycles
// S_HOLD  | one cycle with wl low and bl held; advance row or finish
// S_DONE  | one-cycle completion pulse
module cby_blwl_config_ctrl #(
    parameter int NUM_BL   = 72,
    parameter int NUM_WL   = 72,
    parameter int DIN_W    = 8,
    parameter int WL_PULSE = 2,
    localparam int RW      = (NUM_WL > 1) ? $clog2(NUM_WL) : 1
) (
    input  logic              prog_clk,
    input  logic              prog_rst_n,
    input  logic              start,
    input  logic [DIN_W-1:0]  din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [NUM_BL-1:0] bl,
    output logic [NUM_WL-1:0] wl,
    output logic              busy,
    output logic              done,
    output logic [RW-1:0]     row_idx
);

    localparam int WPR = (NUM_BL + DIN_W - 1) / DIN_W;
    localparam int CW  = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int PW  = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NUM_BL-1:0] r_shadow;
    logic [NUM_BL-1:0] w_shadow_nxt;
    logic [CW-1:0]     r_word_cnt;
    logic [RW-1:0]     r_row_idx;
    logic [PW-1:0]     r_pulse_cnt;
    logic              w_last_word;
    logic              w_last_row;

    assign w_last_word = (r_word_cnt == CW'(WPR - 1));
    assign w_last_row  = (r_row_idx == RW'(NUM_WL - 1));

    // Each shadow bit takes din only when the current word covers it; bits
    // past NUM_BL in the final word simply have no destination.
    for (genvar g = 0; g < NUM_BL; g++) begin : g_slice
        assign w_shadow_nxt[g] = (r_word_cnt == CW'(g / DIN_W)) ? din[g % DIN_W] : r_shadow[g];
    end

    // Word line is a pure decode of state and row, so it can only be one-hot
    // and only during PULSE; async reset clears it immediately.
    for (genvar g = 0; g < NUM_WL; g++) begin : g_wl
        assign wl[g] = (r_state == S_PULSE) && (r_row_idx == RW'(g));
    end

    assign bl      = r_shadow;
    assign row_idx = r_row_idx;

    // State register.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded outputs; din_ready depends on state only.
    always_comb begin
        w_state_nxt = r_state;
        din_ready   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                din_ready = 1'b1;
                if (din_valid && w_last_word) begin
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                w_state_nxt = S_PULSE;
            end
            S_PULSE: begin
                if (r_pulse_cnt == '0) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                w_state_nxt = w_last_row ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                busy        = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: shadow frame, word counter, row index and pulse down-counter.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_shadow    <= '0;
            r_word_cnt  <= '0;
            r_row_idx   <= '0;
            r_pulse_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_row_idx  <= '0;
                        r_word_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (din_valid) begin
                        r_shadow   <= w_shadow_nxt;
                        r_word_cnt <= w_last_word ? '0 : r_word_cnt + 1'b1;
                    end
                end
                S_SETUP: begin
                    r_pulse_cnt <= PW'(WL_PULSE - 1);
                end
                S_PULSE: begin
                    if (r_pulse_cnt != '0) begin
                        r_pulse_cnt <= r_pulse_cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!w_last_row) begin
                        r_row_idx  <= r_row_idx + 1'b1;
                        r_word_cnt <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cby_blwl_config_ctrl.sv
// Bench for cby_blwl_config_ctrl: a table of cycle vectors on a 10-bit,
// 4-bit-word instance; a hand-timed single-row run; and randomized
// multi-row sessions on the default instance against a schedule model.
module tb_cby_blwl_config_ctrl;

    localparam int NBL   = 72;
    localparam int NWL   = 72;
    localparam int DW    = 8;
    localparam int PULSE = 2;
    localparam int WPR   = (NBL + DW - 1) / DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp_v);
        end
    endtask

    // ---------------- default instance (72 x 72, 8-bit words) -------------
    logic            m_start = 0, m_valid = 0;
    logic [DW-1:0]   m_din = '0;
    logic            mo_ready, mo_busy, mo_done;
    logic [NBL-1:0]  mo_bl;
    logic [NWL-1:0]  mo_wl;
    logic [6:0]      mo_row;

    cby_blwl_config_ctrl u_main (
        .prog_clk(clk), .prog_rst_n(rst_n), .start(m_start), .din(m_din),
        .din_valid(m_valid), .din_ready(mo_ready), .bl(mo_bl), .wl(mo_wl),
        .busy(mo_busy), .done(mo_done), .row_idx(mo_row)
    );

    // ---------------- partial-word instance (10 BL, 4-bit words, 1 row) ---
    logic            s_start = 0, s_valid = 0;
    logic [3:0]      s_din = '0;
    logic            so_ready, so_busy, so_done;
    logic [9:0]      so_bl;
    logic [0:0]      so_wl;
    logic [0:0]      so_row;

    cby_blwl_config_ctrl #(.NUM_BL(10), .NUM_WL(1), .DIN_W(4), .WL_PULSE(2)) u_small (
        .prog_clk(clk), .prog_rst_n(rst_n), .start(s_start), .din(s_din),
        .din_valid(s_valid), .din_ready(so_ready), .bl(so_bl), .wl(so_wl),
        .busy(so_busy), .done(so_done), .row_idx(so_row)
    );

    // ---------------- single-row default-width instance -------------------
    logic            u1_start = 0, u1_valid = 0;
    logic [DW-1:0]   u1_din = '0;
    logic            uo_ready, uo_busy, uo_done;
    logic [NBL-1:0]  uo_bl;
    logic [0:0]      uo_wl;
    logic [0:0]      uo_row;

    cby_blwl_config_ctrl #(.NUM_WL(1)) u_one (
        .prog_clk(clk), .prog_rst_n(rst_n), .start(u1_start), .din(u1_din),
        .din_valid(u1_valid), .din_ready(uo_ready), .bl(uo_bl), .wl(uo_wl),
        .busy(uo_busy), .done(uo_done), .row_idx(uo_row)
    );

    // ---------------- schedule model for u_main ---------------------------
    // A row is described by the cycle of its last accepted word (mdl_ts):
    // settle at ts+1, pulse ts+2..ts+1+PULSE, hold ts+PULSE+2, done ts+PULSE+3.
    bit             mon_en = 0;
    bit             mdl_active;
    int             mdl_row, mdl_words, mdl_ts;
    logic [NBL-1:0] mdl_frame;
    logic [NWL-1:0] exp_wl;
    bit             exp_ready, exp_done, in_win, was_active;

    task automatic mdl_reset();
        mdl_active = 0;
        mdl_row    = 0;
        mdl_words  = 0;
        mdl_ts     = -1;
        mdl_frame  = '0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            exp_wl = '0;
            in_win = (mdl_ts >= 0) && (cyc > mdl_ts);
            if (mdl_ts >= 0 && cyc >= mdl_ts + 2 && cyc <= mdl_ts + 1 + PULSE)
                exp_wl[mdl_row] = 1'b1;
            exp_ready = mdl_active && !in_win;
            exp_done  = (mdl_ts >= 0) && (mdl_row == NWL - 1) && (cyc == mdl_ts + PULSE + 3);
            chk("main_wl", mo_wl, exp_wl);
            chk("main_bl", mo_bl, mdl_frame);
            chk("main_ready", mo_ready, exp_ready);
            chk("main_busy", mo_busy, mdl_active);
            chk("main_done", mo_done, exp_done);
            chk("main_row", mo_row, mdl_row);
            was_active = mdl_active;
            if (exp_ready && m_valid) begin
                mdl_frame[mdl_words*DW +: DW] = m_din;
                mdl_words++;
                if (mdl_words == WPR) mdl_ts = cyc;
            end
            if (mdl_ts >= 0 && cyc == mdl_ts + PULSE + 2 && mdl_row < NWL - 1) begin
                mdl_row++;
                mdl_words = 0;
                mdl_ts    = -1;
            end
            if (exp_done) begin
                mdl_active = 0;
                mdl_ts     = -1;
            end
            if (!was_active && m_start) begin
                mdl_active = 1;
                mdl_row    = 0;
                mdl_words  = 0;
            end
        end
    end

    // mode 0: random valid, 1: toggle every cycle, 2: always valid.
    task automatic run_main(input int mode, input bit stop_row3, output bit hit);
        int budget;
        bit tog;
        hit    = 0;
        budget = 0;
        tog    = 1;
        @(posedge clk); #1;
        m_start = 1;
        m_valid = 1'($urandom_range(1));
        m_din   = DW'($urandom);
        while (budget < 6000) begin
            @(posedge clk); #1;
            m_start = ($urandom_range(31) == 0);
            case (mode)
                0:       m_valid = ($urandom_range(99) < 60);
                1:       begin m_valid = tog; tog = !tog; end
                default: m_valid = 1'b1;
            endcase
            m_din = DW'($urandom);
            if (stop_row3 && mo_wl[3]) begin
                hit = 1;
                break;
            end
            if (mo_done) begin
                m_start = 1'b1;
                break;
            end
            budget++;
        end
        chk("session_in_budget", (budget < 6000), 1'b1);
        if (!stop_row3) begin
            @(posedge clk); #1;
            m_start = 0;
            m_valid = 1;
            repeat (3) @(posedge clk);
            #1;
            m_valid = 0;
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    // ---------------- vector table for u_small ----------------------------
    typedef struct {
        logic       start;
        logic [3:0] din;
        logic       valid;
        logic       ready;
        logic       busy;
        logic       done;
        logic       wl;
        logic [9:0] bl;
    } vec_t;

    vec_t tbl[12];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main_seq
        int  t0, first, nwl, ndone, dcyc;
        bit  hit;

        tbl[0]  = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000};
        tbl[1]  = '{1'b0, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'h000};
        tbl[2]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h00F};
        tbl[3]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'h00F};
        tbl[4]  = '{1'b0, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'h00F};
        tbl[5]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h30F};
        tbl[6]  = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h30F};
        tbl[7]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h30F};
        tbl[8]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h30F};
        tbl[9]  = '{1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'h30F};
        tbl[10] = '{1'b0, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h30F};
        tbl[11] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h30F};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_main_busy", mo_busy, 1'b0);
        chk("rst_main_ready", mo_ready, 1'b0);
        chk("rst_main_wl", mo_wl, '0);
        chk("rst_main_bl", mo_bl, '0);
        chk("rst_main_row", mo_row, '0);
        chk("rst_small_bl", so_bl, '0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        mdl_reset();
        mon_en = 1;

        // partial-word vectors
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            s_start = tbl[i].start;
            s_din   = tbl[i].din;
            s_valid = tbl[i].valid;
            @(negedge clk);
            chk($sformatf("small_ready[%0d]", i), so_ready, tbl[i].ready);
            chk($sformatf("small_busy[%0d]", i), so_busy, tbl[i].busy);
            chk($sformatf("small_done[%0d]", i), so_done, tbl[i].done);
            chk($sformatf("small_wl[%0d]", i), so_wl, tbl[i].wl);
            chk($sformatf("small_bl[%0d]", i), so_bl, tbl[i].bl);
        end
        @(posedge clk); #1;
        s_start = 0;
        s_valid = 0;

        // single row: words 1..9 back to back
        @(posedge clk); #1;
        u1_start = 1;
        t0 = cyc;
        @(posedge clk); #1;
        u1_start = 0;
        for (int k = 1; k <= 9; k++) begin
            u1_din   = DW'(k);
            u1_valid = 1;
            @(negedge clk);
            chk("one_ready", uo_ready, 1'b1);
            chk("one_wl_early", uo_wl, 1'b0);
            @(posedge clk); #1;
        end
        u1_valid = 0;
        first = -1;
        nwl   = 0;
        ndone = 0;
        dcyc  = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (uo_wl[0]) begin
                nwl++;
                if (first < 0) first = cyc;
            end
            if (uo_done) begin
                ndone++;
                dcyc = cyc;
            end
        end
        chk("one_wl_start", first - t0, 11);
        chk("one_wl_len", nwl, 2);
        chk("one_done_cyc", dcyc - t0, 14);
        chk("one_done_cnt", ndone, 1);
        chk("one_bl", uo_bl, 72'h09_08_07_06_05_04_03_02_01);
        chk("one_busy_end", uo_busy, 1'b0);

        // multi-row sessions on the default instance
        run_main(1, 1'b0, hit);
        run_main(0, 1'b0, hit);

        // async reset in the middle of row 3's pulse
        run_main(2, 1'b1, hit);
        chk("rst_reached_row3", hit, 1'b1);
        mon_en = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wl", mo_wl, '0);
        chk("arst_bl", mo_bl, '0);
        chk("arst_busy", mo_busy, 1'b0);
        chk("arst_ready", mo_ready, 1'b0);
        chk("arst_done", mo_done, 1'b0);
        chk("arst_row", mo_row, '0);
        m_start = 0;
        m_valid = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        mdl_reset();
        mon_en = 1;
        repeat (4) @(posedge clk);
        #1;

        run_main(0, 1'b0, hit);

        mon_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cby_blwl_config_ctrl.md
Name: cby_blwl_config_ctrl

Overview:
Configuration sequencer for memory-bank (BL/WL) programmed connection blocks such as the CBY tiles with 72 BL / 72 WL configuration inputs. It accepts a stream of configuration words over a valid/ready handshake and assembles one BL frame per WL row in a shadow register. It then drives the frame on bl with the selected wl line pulsed, row by row, until every row is written. It sits between the fabric-level configuration port and each tile's bl/wl inputs.

Parameters:
NUM_BL, 72, number of bit lines (frame width in bits)
NUM_WL, 72, number of word-line rows to program per session (>=1)
DIN_W, 8, width of incoming configuration word (1..NUM_BL)
WL_PULSE, 2, cycles wl is held high per row (>=1)

Ports:
prog_clk  input  1  configuration clock, all state on rising edge
prog_rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a programming session
din  input  DIN_W  configuration word
din_valid  input  1  din is valid
din_ready  output  1  controller accepts din this cycle
bl  output  NUM_BL  bit-line drive, index 0..NUM_BL-1
wl  output  NUM_WL  one-hot word-line drive, index 0..NUM_WL-1
busy  output  1  session in progress
done  output  1  one-cycle pulse when the last row completes
row_idx  output  clog2(NUM_WL) (min 1)  current row being loaded/written

Behaviour:
- Reset (prog_rst_n low, asynchronous): state IDLE; bl=0, wl=0, din_ready=0, busy=0, done=0, row_idx=0, word counter=0. Reset mid-session aborts immediately; no partial wl pulse survives.
- WPR = ceil(NUM_BL/DIN_W) words per row. Word k, bit j maps to bl shadow bit k*DIN_W+j; bits with index >= NUM_BL in the last word are discarded.
- States: IDLE -> LOAD -> SETUP -> PULSE -> HOLD -> (LOAD | DONE) -> IDLE.
- IDLE: din_ready=0, busy=0. start=1 -> LOAD next cycle, row_idx=0, word counter=0, busy=1. din_valid in IDLE is ignored.
- LOAD: din_ready=1. A transfer occurs when din_valid & din_ready. Each transfer writes its slice into the shadow and increments the counter. The transfer of word WPR-1 -> SETUP. Stalls indefinitely while din_valid=0.
- bl always presents the shadow register. bl changes only in LOAD and is stable from SETUP through HOLD.
- SETUP: 1 cycle, din_ready=0, wl=0 (BL settle).
- PULSE: wl[row_idx]=1, all other wl bits 0, for exactly WL_PULSE cycles.
- HOLD: 1 cycle, wl=0, bl unchanged. If row_idx==NUM_WL-1 -> DONE. Otherwise row_idx+1, counter=0, shadow kept (overwritten by the next loads), -> LOAD.
- DONE: 1 cycle, done=1, busy=1. Next cycle IDLE with busy=0. The shadow and bl keep the last frame.
- start while busy is ignored (no restart, no error). start in the DONE cycle is ignored.
- din_ready is registered/state-derived, with no combinational path from din_valid.
- wl is never multi-hot, and is never high outside PULSE.
- Total cycles per row with continuous valid: WPR + 1 + WL_PULSE + 1.

Test Plan:
- Reset: assert prog_rst_n=0 mid-PULSE on row 3 -> wl=0, bl=0, busy=0, din_ready=0 in the same cycle (async). After release, the controller is in IDLE.
- Single row, defaults with NUM_WL=1: start, then 9 words 0x01..0x09 back-to-back -> bl[0:7]=0x01 ... bl[64:71]=0x09. wl[0] high exactly 2 cycles, starting 2 cycles after the 9th transfer. done pulses 1 cycle. Total start->done = 1+9+1+2+1+1 cycles.
- Partial word: NUM_BL=10, DIN_W=4, 3 words 0xF,0x0,0xF -> bl bits 0-3=1, 4-7=0, 8-9=1. Upper 2 bits of word 3 dropped; WPR=3.
- Backpressure: din_valid toggled 1/0 every cycle -> only valid cycles are counted. The frame is correct, and no wl assertion occurs before the 9th accepted word.
- Multi-row: NUM_WL=72, a unique frame per row -> wl[r] is one-hot with bl equal to frame r while pulsed. row_idx goes 0..71. done pulses once, after row 71.
- Ignored stimuli: start pulsed during LOAD and in DONE, and din_valid=1 in IDLE -> no state change, din_ready stays 0 in IDLE, and there is no extra session.
